// File: rtl/ir_queue.sv
// ir_queue -- multi-entry instruction register between LC-3b fetch and decode.
//
// Circular FIFO of DEPTH {instruction word, PC} entries with valid/ready on
// both sides. The head entry is sliced into the decode fields the control
// unit needs. When the queue is empty, every field and out_pc read as 0.
// A synchronous flush discards everything so that fetch can run ahead.
//
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   flush              synchronous discard of all entries; beats push/pop
//   in_valid/in/in_pc  fetch side: word and its PC; in_ready = not full
//   out_ready          decode consumes the head entry
//   out_valid, out_pc  head entry present, and its PC
//   count              occupancy, 0..DEPTH
//   opcode..jsr_enable decode slices of the head word
module ir_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [15:0]                in,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [3:0]                 opcode,
    output logic [2:0]                 dest,
    output logic [2:0]                 src1,
    output logic [2:0]                 src2,
    output logic [3:0]                 offset4,
    output logic [4:0]                 offset5,
    output logic [5:0]                 offset6,
    output logic [7:0]                 trapvect8,
    output logic [8:0]                 offset9,
    output logic [10:0]                offset11,
    output logic                       d_enable,
    output logic                       imm_enable,
    output logic                       jsr_enable
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]         word;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic          push, pop;
    entry_t        head_e;
    logic [15:0]   hw;

    // Both handshakes depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    // DEPTH does not have to be a power of 2, so wrap explicitly instead of
    // relying on the pointer overflowing.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset. A push that coincides with a flush is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= {in, in_pc};
    end

    // Gate with out_valid so that an empty queue decodes as all zeros.
    assign head_e = mem[head];
    assign hw     = out_valid ? head_e.word : '0;
    assign out_pc = out_valid ? head_e.pc   : '0;

    assign opcode     = hw[15:12];
    assign dest       = hw[11:9];
    assign src1       = hw[8:6];
    assign src2       = hw[2:0];
    assign offset4    = hw[3:0];
    assign offset5    = hw[4:0];
    assign offset6    = hw[5:0];
    assign trapvect8  = hw[7:0];
    assign offset9    = hw[8:0];
    assign offset11   = hw[10:0];
    assign d_enable   = hw[4];
    assign imm_enable = hw[5];
    assign jsr_enable = hw[11];
endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: instance A is DEPTH=4 and runs the directed steps;
// instance B is DEPTH=3 and runs random push/pop. Both are compared against
// a SystemVerilog queue of {word, pc} used as the reference model.
module tb_ir_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- instance A, DEPTH=4 ----------------
    logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [15:0] a_in = 0, a_in_pc = 0;
    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_pc;
    logic [2:0]  a_count;
    logic [3:0]  a_opcode, a_offset4;
    logic [2:0]  a_dest, a_src1, a_src2;
    logic [4:0]  a_offset5;
    logic [5:0]  a_offset6;
    logic [7:0]  a_trapvect8;
    logic [8:0]  a_offset9;
    logic [10:0] a_offset11;
    logic        a_d_enable, a_imm_enable, a_jsr_enable;

    ir_queue #(.DEPTH(4), .PC_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush), .in_valid(a_in_valid),
        .in(a_in), .in_pc(a_in_pc), .in_ready(a_in_ready), .out_ready(a_out_ready),
        .out_valid(a_out_valid), .out_pc(a_out_pc), .count(a_count),
        .opcode(a_opcode), .dest(a_dest), .src1(a_src1), .src2(a_src2),
        .offset4(a_offset4), .offset5(a_offset5), .offset6(a_offset6),
        .trapvect8(a_trapvect8), .offset9(a_offset9), .offset11(a_offset11),
        .d_enable(a_d_enable), .imm_enable(a_imm_enable), .jsr_enable(a_jsr_enable)
    );

    // ---------------- instance B, DEPTH=3 ----------------
    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [15:0] b_in = 0, b_in_pc = 0;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_pc;
    logic [1:0]  b_count;
    logic [3:0]  b_opcode, b_offset4;
    logic [2:0]  b_dest, b_src1, b_src2;
    logic [4:0]  b_offset5;
    logic [5:0]  b_offset6;
    logic [7:0]  b_trapvect8;
    logic [8:0]  b_offset9;
    logic [10:0] b_offset11;
    logic        b_d_enable, b_imm_enable, b_jsr_enable;

    ir_queue #(.DEPTH(3), .PC_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid),
        .in(b_in), .in_pc(b_in_pc), .in_ready(b_in_ready), .out_ready(b_out_ready),
        .out_valid(b_out_valid), .out_pc(b_out_pc), .count(b_count),
        .opcode(b_opcode), .dest(b_dest), .src1(b_src1), .src2(b_src2),
        .offset4(b_offset4), .offset5(b_offset5), .offset6(b_offset6),
        .trapvect8(b_trapvect8), .offset9(b_offset9), .offset11(b_offset11),
        .d_enable(b_d_enable), .imm_enable(b_imm_enable), .jsr_enable(b_jsr_enable)
    );

    logic [31:0] qa[$];   // {word, pc}
    logic [31:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full comparison of instance A against the model head.
    task automatic check_a(input string tag);
        logic [15:0] w;
        logic [15:0] pc;
        w  = (qa.size() != 0) ? qa[0][31:16] : 16'h0;
        pc = (qa.size() != 0) ? qa[0][15:0]  : 16'h0;
        chk({tag, ".count"},     32'(a_count),     32'(qa.size()));
        chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(qa.size() != 0));
        chk({tag, ".in_ready"},  32'(a_in_ready),  32'(qa.size() != 4));
        chk({tag, ".out_pc"},    32'(a_out_pc),    32'(pc));
        chk({tag, ".word"},      32'({a_opcode, a_jsr_enable, a_offset11}), 32'(w));
        chk({tag, ".fields"},
            32'({a_dest, a_src1, a_src2, a_offset4, a_offset5, a_offset6,
                 a_trapvect8[7:6], a_offset9[8:7], a_d_enable, a_imm_enable}),
            32'({w[11:9], w[8:6], w[2:0], w[3:0], w[4:0], w[5:0],
                 w[7:6], w[8:7], w[4], w[5]}));
    endtask

    // One clock of instance A; the model moves by the pre-edge occupancy.
    task automatic step_a(input bit v, input logic [15:0] w, input logic [15:0] pc,
                          input bit rdy, input bit fl, input string tag);
        bit push, pop;
        a_in_valid = v; a_in = w; a_in_pc = pc; a_out_ready = rdy; a_flush = fl;
        push = v && (qa.size() < 4);
        pop  = rdy && (qa.size() > 0);
        @(posedge clk); #1;
        if (fl) qa.delete();
        else begin
            if (pop)  void'(qa.pop_front());
            if (push) qa.push_back({w, pc});
        end
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
        check_a(tag);
    endtask

    task automatic step_b(input bit v, input logic [15:0] w, input logic [15:0] pc,
                          input bit rdy);
        bit push, pop;
        logic [31:0] exp;
        b_in_valid = v; b_in = w; b_in_pc = pc; b_out_ready = rdy;
        push = v && (qa.size() >= 0) && (qb.size() < 3);
        pop  = rdy && (qb.size() > 0);
        @(posedge clk); #1;
        if (pop)  void'(qb.pop_front());
        if (push) qb.push_back({w, pc});
        b_in_valid = 0; b_out_ready = 0;
        exp = (qb.size() != 0) ? qb[0] : 32'h0;
        chk("rand.count",     32'(b_count),     32'(qb.size()));
        chk("rand.count_max", 32'(b_count <= 2'd3), 32'd1);
        chk("rand.in_ready",  32'(b_in_ready),  32'(qb.size() != 3));
        chk("rand.head",      {b_opcode, b_jsr_enable, b_offset11, b_out_pc}, exp);
    endtask

    initial begin
        // Reset state
        #2;
        check_a("reset");
        chk("reset.b_count", 32'(b_count), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // First push: visible after exactly one edge
        step_a(1, 16'h1283, 16'h3000, 0, 0, "add");
        chk("add.opcode", 32'(a_opcode), 32'd1);
        chk("add.dest",   32'(a_dest),   32'd1);
        chk("add.src1",   32'(a_src1),   32'd2);
        chk("add.src2",   32'(a_src2),   32'd3);
        chk("add.imm",    32'(a_imm_enable), 32'd0);
        chk("add.pc",     32'(a_out_pc), 32'h3000);
        step_a(0, 0, 0, 1, 0, "drain0");

        // Fill to DEPTH, a push while full is ignored, then drain in order
        step_a(1, 16'h1265, 16'h3002, 0, 0, "fill1");
        step_a(1, 16'h6042, 16'h3004, 0, 0, "fill2");
        step_a(1, 16'h0E05, 16'h3006, 0, 0, "fill3");
        step_a(1, 16'hF025, 16'h3008, 0, 0, "fill4");
        chk("full.in_ready", 32'(a_in_ready), 32'd0);
        chk("full.count",    32'(a_count),    32'd4);
        step_a(1, 16'h5000, 16'h300A, 0, 0, "overflow");
        chk("imm.offset5", 32'(a_offset5), 32'd5);
        chk("imm.enable",  32'(a_imm_enable), 32'd1);
        chk("imm.src1",    32'(a_src1), 32'd1);
        for (int i = 0; i < 4; i++) step_a(0, 0, 0, 1, 0, "drain");
        chk("drained.valid", 32'(a_out_valid), 32'd0);

        // Simultaneous push/pop at count=2 across pointer wrap
        step_a(1, 16'h2001, 16'h4000, 0, 0, "pp_pre0");
        step_a(1, 16'h2002, 16'h4002, 0, 0, "pp_pre1");
        for (int i = 0; i < 10; i++) begin
            step_a(1, 16'h3000 + 16'(i), 16'h5000 + 16'(2*i), 1, 0, "pushpop");
            chk("pushpop.count", 32'(a_count), 32'd2);
        end

        // Flush at count=3 with a simultaneous push
        step_a(1, 16'h1111, 16'h6000, 0, 0, "pre_flush");
        chk("pre_flush.count", 32'(a_count), 32'd3);
        step_a(1, 16'h4800, 16'h6002, 0, 1, "flush");
        chk("flush.opcode", 32'(a_opcode), 32'd0);
        step_a(0, 0, 0, 1, 0, "post_flush");

        // Async reset mid-cycle at count=2
        step_a(1, 16'hABCD, 16'h7000, 0, 0, "ar0");
        step_a(1, 16'h9876, 16'h7002, 0, 0, "ar1");
        #2 reset_n = 1'b0;
        #1;
        qa.delete();
        check_a("async_reset");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check_a("after_release");
        step_a(1, 16'h1283, 16'h3100, 0, 0, "first_after_reset");

        // DEPTH=3 random push/pop against the scoreboard
        for (int i = 0; i < 40; i++)
            step_b($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                   $urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
